cpu_mem_responder: RTL and testbench

- Memory-side responder for the RISC5 data bus.
- Accepts word and byte load/store cycles (adr, rd, wr, ben, outbus) and returns inbus / stallX to the CPU.
- Translates each access into a single req/ack transaction on a slow word-wide memory port (SDRAM controller side).
- Includes a watchdog that completes hung transactions with an error pattern, so the CPU never deadlocks.

---
 rtl/cpu_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the RISC5 data bus.
// Turns each CPU load/store into one req/ack transaction on a word-wide memory port,
// stalls the CPU until completion, and force-completes hung transactions with an error.

module cpu_mem_responder #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [23:0] adr,
    input  logic        rd,
    input  logic        wr,
    input  logic        ben,
    input  logic [31:0] outbus,
    output logic [31:0] inbus,
    output logic        stallX,
    output logic        mem_req,
    output logic        mem_we,
    output logic [21:0] mem_adr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    // Last counter value before a hung transaction is force-completed.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [21:0] mem_adr_q, mem_adr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inbus_q, inbus_d;
    logic        err_q, err_d;

    logic        strobe;
    logic        timeout_hit;
    logic [3:0]  lane_be;

    assign strobe      = rd | wr;
    assign timeout_hit = (cnt_q == TimeoutLast);

    // Byte-lane enable decoded from the low address bits.
    always_comb begin
        lane_be = 4'b0001;
        unique case (adr[1:0])
            2'b00:   lane_be = 4'b0001;
            2'b01:   lane_be = 4'b0010;
            2'b10:   lane_be = 4'b0100;
            2'b11:   lane_be = 4'b1000;
            default: lane_be = 4'b0001;
        endcase
    end

    // State register; reset wins over ce, otherwise advance only on ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a strobe is only recognised from idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (strobe) state_d = StWait;
            StWait:  if (mem_ack || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stall while a strobe is pending in idle or a transaction is outstanding.
    always_comb begin
        stallX = ((state_q == StIdle) && strobe) || (state_q == StWait);
    end

    // Datapath next-values: latch the request, complete on ack or on timeout.
    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        inbus_d     = inbus_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    // rd and wr together are treated as a write.
                    mem_we_d    = wr;
                    mem_adr_d   = adr[23:2];
                    mem_wdata_d = outbus;
                    // Reads always fetch the full word; the CPU picks the lane.
                    mem_be_d    = (wr && ben) ? lane_be : 4'b1111;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    // Ack beats a coincident timeout.
                    mem_req_d = 1'b0;
                    if (!mem_we_q) inbus_d = mem_rdata;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!mem_we_q) inbus_d = ERR_WORD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; frozen while ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            inbus_q     <= '0;
            err_q       <= 1'b0;
        end else if (ce) begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            inbus_q     <= inbus_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign inbus     = inbus_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: inputs change on the falling edge,
// outputs are checked on the falling edge (or #1 after an input change for stallX).

module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst, ce, rd, wr, ben, mem_ack;
    logic [23:0] adr;
    logic [31:0] outbus, mem_rdata;
    logic [31:0] inbus, mem_wdata;
    logic        stallX, mem_req, mem_we, err;
    logic [21:0] mem_adr;
    logic [3:0]  mem_be;

    int passed = 0;
    int total  = 0;
    int req_starts = 0;

    cpu_mem_responder #(
        .TIMEOUT (8),
        .ERR_WORD(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .adr      (adr),
        .rd       (rd),
        .wr       (wr),
        .ben      (ben),
        .outbus   (outbus),
        .inbus    (inbus),
        .stallX   (stallX),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Count memory transactions issued.
    always @(posedge mem_req) req_starts++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; rd = 1'b0; wr = 1'b0; ben = 1'b0;
        adr = '0; outbus = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_inbus", inbus, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_stall", 32'(stallX), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word read, ack in third WAIT cycle
        adr = 24'h000104; rd = 1'b1; ben = 1'b0;
        #1 chk("rd_stall_idle", 32'(stallX), 32'd1);
        @(negedge clk);                     // WAIT 1
        chk("rd_req", 32'(mem_req), 32'd1);
        chk("rd_adr", 32'(mem_adr), 32'h41);
        chk("rd_be", 32'(mem_be), 32'hF);
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_stall_w1", 32'(stallX), 32'd1);
        @(negedge clk);                     // WAIT 2
        chk("rd_stall_w2", 32'(stallX), 32'd1);
        @(negedge clk);                     // WAIT 3
        chk("rd_stall_w3", 32'(stallX), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0; mem_rdata = '0;
        chk("rd_done_stall", 32'(stallX), 32'd0);
        chk("rd_done_inbus", inbus, 32'h12345678);
        chk("rd_done_req", 32'(mem_req), 32'd0);
        rd = 1'b0;
        @(negedge clk);                     // IDLE
        chk("rd_idle_req", 32'(mem_req), 32'd0);
        chk("rd_one_req", 32'(req_starts), 32'd1);

        // Byte store to lane 3, ack in first WAIT cycle
        adr = 24'h000203; wr = 1'b1; ben = 1'b1; outbus = 32'hA5A5A5A5;
        @(negedge clk);                     // WAIT
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_be", 32'(mem_be), 32'h8);
        chk("st_adr", 32'(mem_adr), 32'h80);
        chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ack = 1'b1;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0;
        chk("st_done_stall", 32'(stallX), 32'd0);
        chk("st_done_req", 32'(mem_req), 32'd0);
        chk("st_inbus_kept", inbus, 32'h12345678);
        wr = 1'b0; ben = 1'b0;
        @(negedge clk);                     // IDLE
        chk("st_reqs", 32'(req_starts), 32'd2);

        // ce gating during a read with memory latency 2
        adr = 24'h000010; rd = 1'b1;
        @(negedge clk);                     // WAIT, cnt 0
        chk("ce_req", 32'(mem_req), 32'd1);
        ce = 1'b0;
        @(negedge clk);                     // frozen
        chk("ce_frz_req", 32'(mem_req), 32'd1);
        chk("ce_frz_adr", 32'(mem_adr), 32'h4);
        chk("ce_frz_stall", 32'(stallX), 32'd1);
        ce = 1'b1;
        @(negedge clk);                     // WAIT, cnt 1
        ce = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;  // must be ignored
        @(negedge clk);
        mem_ack = 1'b0;
        chk("ce_ack_ign_req", 32'(mem_req), 32'd1);
        chk("ce_ack_ign_inbus", inbus, 32'h12345678);
        ce = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0; ce = 1'b0;
        chk("ce_done_inbus", inbus, 32'hCAFEF00D);
        chk("ce_done_stall", 32'(stallX), 32'd0);
        @(negedge clk);                     // still DONE, frozen
        chk("ce_done_frz_stall", 32'(stallX), 32'd0);
        ce = 1'b1; rd = 1'b0;
        @(negedge clk);                     // IDLE
        chk("ce_reqs", 32'(req_starts), 32'd3);

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_req", 32'(mem_req), 32'd0);
        chk("idle_ack_inbus", inbus, 32'hCAFEF00D);
        chk("idle_ack_stall", 32'(stallX), 32'd0);

        // Back-to-back read then word write, strobe held through DONE
        adr = 24'h000020; rd = 1'b1;
        @(negedge clk);                     // WAIT
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0;
        chk("b2b_rd_inbus", inbus, 32'h11112222);
        chk("b2b_rd_stall", 32'(stallX), 32'd0);
        rd = 1'b0; wr = 1'b1; adr = 24'h000024; outbus = 32'h33334444;
        @(negedge clk);                     // IDLE with strobe
        chk("b2b_no_dup_req", 32'(mem_req), 32'd0);
        chk("b2b_idle_stall", 32'(stallX), 32'd1);
        @(negedge clk);                     // WAIT
        chk("b2b_wr_we", 32'(mem_we), 32'd1);
        chk("b2b_wr_adr", 32'(mem_adr), 32'h9);
        chk("b2b_wr_be", 32'(mem_be), 32'hF);
        mem_ack = 1'b1;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0;
        chk("b2b_wr_stall", 32'(stallX), 32'd0);
        wr = 1'b0;
        @(negedge clk);                     // IDLE
        chk("b2b_reqs", 32'(req_starts), 32'd5);

        // Timeout: read with no ack, TIMEOUT=8
        adr = 24'h000040; rd = 1'b1;
        @(negedge clk);                     // WAIT 1
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_req_w%0d", i + 1), 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        chk("to_done_req", 32'(mem_req), 32'd0);
        chk("to_done_inbus", inbus, 32'hDEADBEEF);
        chk("to_err", 32'(err), 32'd1);
        chk("to_done_stall", 32'(stallX), 32'd0);
        rd = 1'b0;
        @(negedge clk);                     // IDLE

        // Good write afterwards: err stays set
        adr = 24'h000050; wr = 1'b1; ben = 1'b0; outbus = 32'h01020304;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);                     // DONE
        mem_ack = 1'b0;
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_wr_inbus_kept", inbus, 32'hDEADBEEF);
        wr = 1'b0;
        @(negedge clk);

        // Reset two cycles into WAIT; later ack is ignored
        adr = 24'h000080; rd = 1'b1;
        @(negedge clk);                     // WAIT 1
        @(negedge clk);                     // WAIT 2
        rst = 1'b1; rd = 1'b0;
        @(negedge clk);
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_inbus", inbus, 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_stall", 32'(stallX), 32'd0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mrst_late_ack_req", 32'(mem_req), 32'd0);
        chk("mrst_late_ack_inbus", inbus, 32'd0);
        chk("mrst_late_ack_stall", 32'(stallX), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
